pkt_fifo: RTL and testbench
===========================

PKT_FIFO -- requirements
Module: pkt_fifo

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8, payload width in bits.
REQ-002 SHALL have parameter DEPTH, default 64, entry count; power of two, >= 4.
REQ-003 SHALL have parameter AF_LEVEL, default DEPTH-8, almost_full threshold in entries.
REQ-004 SHALL have ports clk in 1 (the single clock) and rst in 1 (synchronous, active-high reset).
REQ-005 SHALL have ports in_valid in 1, in_data in DATA_WIDTH, in_last in 1, in_bad in 1 (frame error, sampled with in_last), in_ready out 1.
REQ-006 SHALL have ports out_valid out 1, out_data out DATA_WIDTH, out_last out 1, out_ready in 1.
REQ-007 SHALL have ports level out PTR_WIDTH+1 (entries held), frame_count out PTR_WIDTH+1 (complete frames held), almost_full out 1, drop_pulse out 1; PTR_WIDTH = clog2(DEPTH).

Function
REQ-008 SHALL store {in_last, in_data} per entry; pointers wr_ptr, commit_ptr, rd_ptr are PTR_WIDTH+1 bits, so all DEPTH entries are usable.
REQ-009 SHALL accept a word when in_valid && in_ready; in_ready = (wr_ptr - rd_ptr) != DEPTH, registered-state only, no combinational path from out_ready.
REQ-010 SHALL present out_valid = (rd_ptr != commit_ptr); out_data/out_last read combinationally at rd_ptr (first-word fall-through).
REQ-011 SHALL advance rd_ptr by 1 when out_valid && out_ready; out_data SHALL hold stable while out_valid && !out_ready.
REQ-012 SHALL permit accept and read in the same cycle; level changes by (accept - read), never exceeding DEPTH or going below 0.
REQ-013 SHALL wrap all pointers modulo 2*DEPTH; full when pointers differ only in MSB.
REQ-014 SHALL set almost_full = (level >= AF_LEVEL), derived from registered state.
REQ-015 SHALL increment frame_count when a frame commits and decrement on a read handshake with out_last=1; both in one cycle leaves it unchanged.
REQ-016 SHALL ignore in_bad when in_last=0 or when the word is not accepted.

Reset
REQ-017 SHALL on rst=1 at a clk edge clear wr_ptr, commit_ptr, rd_ptr, frame_count, the oversize flag and drop_pulse; outputs after reset: in_ready=1, out_valid=0, level=0, almost_full=0 (AF_LEVEL>0), drop_pulse=0.
REQ-018 SHALL discard any partial or unread frame on reset mid-operation; the next accepted word after reset starts a new frame.
REQ-019 SHALL NOT reset storage contents.

Configuration
REQ-020 Macro PKT_FIFO_DROP_EN defined: store-and-forward; commit_ptr SHALL advance to wr_ptr+1 only on accepting in_last=1 with in_bad=0, so a frame becomes readable the cycle after its last word is accepted.
REQ-021 With PKT_FIFO_DROP_EN: accepting in_last=1 with in_bad=1 SHALL set wr_ptr to commit_ptr (rollback) and pulse drop_pulse for one cycle.
REQ-022 With PKT_FIFO_DROP_EN: if wr_ptr - rd_ptr == DEPTH and commit_ptr == rd_ptr (frame larger than FIFO), SHALL set oversize flag, hold in_ready=1, discard words until in_last, then roll back, pulse drop_pulse, clear flag.
REQ-023 Macro undefined: cut-through; commit_ptr SHALL equal wr_ptr every cycle, in_bad ignored, drop_pulse tied 0, no oversize logic; a word is readable the cycle after acceptance.

Structure
REQ-024 SHALL place pointer-width function and entry typedef {last, data} in shared package pkt_fifo_pkg.
REQ-025 SHALL implement storage as sub-module pkt_fifo_ram (1 write port, 1 async read port, no reset).

Verification
REQ-026 DEPTH=8, DROP_EN: write 3-word frame A0..A2, in_bad=0 -> out_valid=0 until cycle after A2 accept; then A0,A1,A2 with out_last on A2; frame_count 1->0.
REQ-027 DROP_EN: write 4-word frame, in_bad=1 on last -> drop_pulse one cycle, level returns to prior value, out_valid stays 0; following good 2-word frame reads out intact.
REQ-028 DEPTH=8, DROP_EN: 12-word frame, reader idle -> in_ready stays 1, drop_pulse on word 12, level=0, no output.
REQ-029 No DROP_EN, DEPTH=8: 8 writes, out_ready=0 -> level=8, in_ready=0, almost_full=1 (AF_LEVEL=6); simultaneous read+write while level=5 keeps level=5.
REQ-030 Reset asserted mid-frame after 2 words with 1 committed frame held -> next cycle level=0, frame_count=0, out_valid=0, in_ready=1.
REQ-031 Wrap: 20 single-word frames (DEPTH=8) with random out_ready -> data order preserved, no loss, level never >8.

Source files
------------

// File: rtl/pkt_fifo_pkg.sv
// Shared types and helpers for the packet FIFO.
// pkt_entry_t is sized for the widest supported payload; narrower builds use the low data bits.
package pkt_fifo_pkg;

  localparam int PKT_MAX_DATA_WIDTH = 64;

  typedef struct packed {
    logic                          last;
    logic [PKT_MAX_DATA_WIDTH-1:0] data;
  } pkt_entry_t;

  function automatic int ptr_width(input int depth);
    return $clog2(depth);
  endfunction

endpackage

// File: rtl/pkt_fifo_ram.sv
// Packet FIFO storage: one synchronous write port, one asynchronous read port.
// Contents are deliberately left unreset.
module pkt_fifo_ram #(
  parameter int WIDTH = 9,
  parameter int DEPTH = 64,
  parameter int AW    = 6
) (
  input  logic             clk,
  input  logic             i_wr_en,
  input  logic [AW-1:0]    i_wr_addr,
  input  logic [WIDTH-1:0] i_wr_data,
  input  logic [AW-1:0]    i_rd_addr,
  output logic [WIDTH-1:0] o_rd_data
);

  logic [WIDTH-1:0] r_mem [DEPTH];

  always_ff @(posedge clk) begin
    if (i_wr_en) begin
      r_mem[i_wr_addr] <= i_wr_data;
    end
  end

  assign o_rd_data = r_mem[i_rd_addr];

endmodule

// File: rtl/pkt_fifo.sv
// Packet FIFO with first-word fall-through output and a count of complete frames held.
// Define PKT_FIFO_DROP_EN for store-and-forward with bad/oversize frame drop; default is cut-through.
module pkt_fifo
  import pkt_fifo_pkg::*;
#(
  parameter int  DATA_WIDTH = 8,
  parameter int  DEPTH      = 64,
  parameter int  AF_LEVEL   = DEPTH - 8,
  localparam int PTR_WIDTH  = ptr_width(DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic                  in_last,
  input  logic                  in_bad,
  output logic                  in_ready,
  output logic                  out_valid,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_last,
  input  logic                  out_ready,
  output logic [PTR_WIDTH:0]    level,
  output logic [PTR_WIDTH:0]    frame_count,
  output logic                  almost_full,
  output logic                  drop_pulse
);

  localparam logic [PTR_WIDTH:0] FULL_FILL = (PTR_WIDTH+1)'(DEPTH);
  localparam logic [PTR_WIDTH:0] AF_FILL   = (PTR_WIDTH+1)'(AF_LEVEL);
  localparam logic [PTR_WIDTH:0] ONE       = (PTR_WIDTH+1)'(1);

  logic [PTR_WIDTH:0]  r_wr_ptr;
  logic [PTR_WIDTH:0]  r_rd_ptr;
  logic [PTR_WIDTH:0]  r_frame_count;
  logic [PTR_WIDTH:0]  w_commit_ptr;
  logic [PTR_WIDTH:0]  w_fill;
  logic                w_full;
  logic                w_accept;
  logic                w_rd_fire;
  logic                w_wr_en;
  logic                w_frame_inc;
  logic                w_frame_dec;
  logic [DATA_WIDTH:0] w_rd_word;
  pkt_entry_t          w_rd_entry;
  logic                w_unused;

  assign w_fill      = r_wr_ptr - r_rd_ptr;
  assign w_full      = (w_fill == FULL_FILL);
  assign w_accept    = in_valid && in_ready;
  assign w_rd_fire   = out_valid && out_ready;
  assign w_frame_dec = w_rd_fire && out_last;

  assign out_valid   = (r_rd_ptr != w_commit_ptr);
  assign level       = w_fill;
  assign almost_full = (w_fill >= AF_FILL);
  assign frame_count = r_frame_count;

`ifdef PKT_FIFO_DROP_EN
  logic [PTR_WIDTH:0] r_commit_ptr;
  logic               r_oversize;
  logic               r_drop_pulse;
  logic               w_discard;

  // A full FIFO with nothing committed holds one frame too large to ever fit: swallow the rest of it.
  assign w_discard    = r_oversize || (w_full && (r_commit_ptr == r_rd_ptr));
  assign in_ready     = !w_full || w_discard;
  assign w_wr_en      = w_accept && !w_discard && !(in_last && in_bad);
  assign w_frame_inc  = w_wr_en && in_last;
  assign w_commit_ptr = r_commit_ptr;
  assign drop_pulse   = r_drop_pulse;
  assign w_unused     = ^w_rd_entry.data;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr     <= '0;
      r_commit_ptr <= '0;
      r_oversize   <= 1'b0;
      r_drop_pulse <= 1'b0;
    end else begin
      r_drop_pulse <= 1'b0;
      if (w_accept) begin
        if (w_discard || (in_last && in_bad)) begin
          if (in_last) begin
            r_wr_ptr     <= r_commit_ptr;
            r_drop_pulse <= 1'b1;
            r_oversize   <= 1'b0;
          end else begin
            r_oversize   <= 1'b1;
          end
        end else begin
          r_wr_ptr <= r_wr_ptr + ONE;
          if (in_last) begin
            r_commit_ptr <= r_wr_ptr + ONE;
          end
        end
      end
    end
  end
`else
  assign in_ready     = !w_full;
  assign w_wr_en      = w_accept;
  assign w_frame_inc  = w_accept && in_last;
  assign w_commit_ptr = r_wr_ptr;
  assign drop_pulse   = 1'b0;
  assign w_unused     = ^{w_rd_entry.data, in_bad};

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
    end else if (w_accept) begin
      r_wr_ptr <= r_wr_ptr + ONE;
    end
  end
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_rd_ptr      <= '0;
      r_frame_count <= '0;
    end else begin
      if (w_rd_fire) begin
        r_rd_ptr <= r_rd_ptr + ONE;
      end
      case ({w_frame_inc, w_frame_dec})
        2'b10:   r_frame_count <= r_frame_count + ONE;
        2'b01:   r_frame_count <= r_frame_count - ONE;
        default: r_frame_count <= r_frame_count;
      endcase
    end
  end

  pkt_fifo_ram #(
    .WIDTH (DATA_WIDTH + 1),
    .DEPTH (DEPTH),
    .AW    (PTR_WIDTH)
  ) u_ram (
    .clk       (clk),
    .i_wr_en   (w_wr_en),
    .i_wr_addr (r_wr_ptr[PTR_WIDTH-1:0]),
    .i_wr_data ({in_last, in_data}),
    .i_rd_addr (r_rd_ptr[PTR_WIDTH-1:0]),
    .o_rd_data (w_rd_word)
  );

  always_comb begin
    w_rd_entry                      = '0;
    w_rd_entry.last                 = w_rd_word[DATA_WIDTH];
    w_rd_entry.data[DATA_WIDTH-1:0] = w_rd_word[DATA_WIDTH-1:0];
  end

  assign out_data = w_rd_entry.data[DATA_WIDTH-1:0];
  assign out_last = w_rd_entry.last;

endmodule

// File: tb/tb_pkt_fifo.sv
// Scoreboard bench for pkt_fifo (DEPTH=8, AF_LEVEL=6); the stimulus pushes expected words and a
// negedge monitor pops and compares every read handshake. Drop tests run when PKT_FIFO_DROP_EN is defined.
module tb_pkt_fifo;

  localparam int DW    = 8;
  localparam int DEPTH = 8;
  localparam int AF    = 6;
  localparam int PW    = 3;
`ifdef PKT_FIFO_DROP_EN
  localparam bit DROP = 1'b1;
`else
  localparam bit DROP = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          in_valid = 1'b0;
  logic [DW-1:0] in_data = '0;
  logic          in_last = 1'b0;
  logic          in_bad = 1'b0;
  logic          in_ready;
  logic          out_valid;
  logic [DW-1:0] out_data;
  logic          out_last;
  logic          out_ready = 1'b0;
  logic [PW:0]   level;
  logic [PW:0]   frame_count;
  logic          almost_full;
  logic          drop_pulse;

  int n_tests   = 0;
  int n_fail    = 0;
  int n_popped  = 0;
  int max_level = 0;
  logic [DW:0] exp_q[$];
  logic [DW:0] pend_q[$];

  always #5 clk = ~clk;

  pkt_fifo #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .AF_LEVEL(AF)) dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_data     (in_data),
    .in_last     (in_last),
    .in_bad      (in_bad),
    .in_ready    (in_ready),
    .out_valid   (out_valid),
    .out_data    (out_data),
    .out_last    (out_last),
    .out_ready   (out_ready),
    .level       (level),
    .frame_count (frame_count),
    .almost_full (almost_full),
    .drop_pulse  (drop_pulse)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end else begin
      $display("[TB] ok %s = %0d", name, act);
    end
  endtask

  // Monitor: every read handshake must match the oldest expected word.
  always @(negedge clk) begin
    if (int'(level) > max_level) max_level = int'(level);
    if (!rst && out_valid === 1'b1 && out_ready === 1'b1) begin
      n_tests++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_out: got last=%0b data=%02h, expected no output", out_last, out_data);
      end else begin
        logic [DW:0] exp;
        exp = exp_q.pop_front();
        n_popped++;
        if ({out_last, out_data} !== exp) begin
          n_fail++;
          $display("FAIL read_word: got last=%0b data=%02h, expected last=%0b data=%02h",
                   out_last, out_data, exp[DW], exp[DW-1:0]);
        end else begin
          $display("[TB] read last=%0b data=%02h", out_last, out_data);
        end
      end
    end
  end

  // Drive one word until accepted; the scoreboard model decides what should come out.
  task automatic send_word(input logic [DW-1:0] d, input logic l, input logic b);
    bit ok;
    ok = 1'b0;
    in_valid = 1'b1; in_data = d; in_last = l; in_bad = b;
    for (int i = 0; i < 200 && !ok; i++) begin
      @(negedge clk);
      if (in_ready === 1'b1) ok = 1'b1;
      @(posedge clk); #1;
    end
    in_valid = 1'b0; in_last = 1'b0; in_bad = 1'b0;
    if (!ok) begin
      n_tests++; n_fail++;
      $display("FAIL accept_timeout: data %02h got in_ready=0 for 200 cycles, expected acceptance", d);
    end else if (!DROP) begin
      exp_q.push_back({l, d});
    end else begin
      pend_q.push_back({l, d});
      if (l) begin
        if (!b && pend_q.size() <= DEPTH)
          foreach (pend_q[k]) exp_q.push_back(pend_q[k]);
        pend_q.delete();
      end
    end
  endtask

  task automatic drain(input string name);
    bit done;
    done = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 100 && !done; i++) begin
      @(negedge clk);
      if (exp_q.size() == 0 && out_valid === 1'b0) done = 1'b1;
    end
    out_ready = 1'b0;
    check({name, "_pending"}, 32'(exp_q.size()), 0);
    check({name, "_out_valid"}, 32'(out_valid), 0);
  endtask

  initial begin
    int popped0;
    bit wr_done;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst_in_ready", 32'(in_ready), 1);
    check("rst_out_valid", 32'(out_valid), 0);
    check("rst_level", 32'(level), 0);
    check("rst_almost_full", 32'(almost_full), 0);
    check("rst_frame_count", 32'(frame_count), 0);
    check("rst_drop_pulse", 32'(drop_pulse), 0);
    @(posedge clk); #1;

    // Fill to DEPTH with the reader stalled; almost_full edge between 5 and 6 entries.
    for (int i = 0; i < 8; i++) begin
      send_word(8'(8'h10 + i), (i == 7), 1'b0);
      if (i == 4 || i == 5) begin
        @(negedge clk);
        check("fill_level", 32'(level), 32'(i + 1));
        check("fill_almost_full", 32'(almost_full), (i == 5) ? 1 : 0);
        @(posedge clk); #1;
      end
    end
    @(negedge clk);
    check("full_level", 32'(level), 8);
    check("full_in_ready", 32'(in_ready), 0);
    check("full_almost_full", 32'(almost_full), 1);
    check("full_frame_count", 32'(frame_count), 1);
    @(posedge clk); #1;
    in_valid = 1'b1; in_data = 8'hEE; in_last = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0; in_last = 1'b0;
    @(negedge clk);
    check("full_write_ignored_level", 32'(level), 8);
    drain("fill");
    check("fill_end_level", 32'(level), 0);
    check("fill_end_frame_count", 32'(frame_count), 0);
    @(posedge clk); #1;

    // Simultaneous accept and read at level 5.
    for (int i = 0; i < 5; i++) send_word(8'(8'h20 + i), 1'b1, 1'b0);
    @(negedge clk);
    check("simul_pre_level", 32'(level), 5);
    @(posedge clk); #1;
    out_ready = 1'b1;
    send_word(8'h25, 1'b1, 1'b0);
    out_ready = 1'b0;
    @(negedge clk);
    check("simul_level", 32'(level), 5);
    check("simul_frame_count", 32'(frame_count), 5);
    drain("simul");
    @(posedge clk); #1;

    // Reset mid-frame with one complete frame held.
    send_word(8'h50, 1'b1, 1'b0);
    send_word(8'h51, 1'b0, 1'b0);
    send_word(8'h52, 1'b0, 1'b0);
    @(negedge clk);
    check("prerst_level", 32'(level), 3);
    check("prerst_frame_count", 32'(frame_count), 1);
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    exp_q.delete();
    pend_q.delete();
    @(negedge clk);
    check("midrst_level", 32'(level), 0);
    check("midrst_frame_count", 32'(frame_count), 0);
    check("midrst_out_valid", 32'(out_valid), 0);
    check("midrst_in_ready", 32'(in_ready), 1);
    @(posedge clk); #1;
    send_word(8'h60, 1'b0, 1'b0);
    send_word(8'h61, 1'b1, 1'b0);
    drain("postrst");
    check("postrst_frame_count", 32'(frame_count), 0);
    @(posedge clk); #1;

    // Pointer wrap: 20 single-word frames against a randomly stalling reader.
    popped0   = n_popped;
    max_level = 0;
    wr_done   = 1'b0;
    fork
      begin
        for (int i = 0; i < 20; i++) send_word(8'(8'h80 + i), 1'b1, 1'b0);
        wr_done = 1'b1;
      end
      begin
        while (!wr_done) begin
          @(posedge clk); #1;
          out_ready = 1'($urandom_range(0, 1));
        end
      end
    join
    drain("wrap");
    check("wrap_words_read", 32'(n_popped - popped0), 20);
    check("wrap_level_bounded", 32'(max_level <= DEPTH), 1);
    @(posedge clk); #1;

`ifdef PKT_FIFO_DROP_EN
    // Store-and-forward: nothing visible until the last word commits.
    out_ready = 1'b1;
    send_word(8'hA0, 1'b0, 1'b0);
    @(negedge clk); check("sf_hold_a0", 32'(out_valid), 0); @(posedge clk); #1;
    send_word(8'hA1, 1'b0, 1'b0);
    @(negedge clk); check("sf_hold_a1", 32'(out_valid), 0); @(posedge clk); #1;
    send_word(8'hA2, 1'b1, 1'b0);
    @(negedge clk);
    check("sf_valid_after_a2", 32'(out_valid), 1);
    check("sf_frame_count", 32'(frame_count), 1);
    drain("sf");
    check("sf_end_frame_count", 32'(frame_count), 0);
    @(posedge clk); #1;

    // Bad frame rolls back, then a good frame passes intact.
    for (int i = 0; i < 4; i++) send_word(8'(8'hB0 + i), (i == 3), (i == 3));
    @(negedge clk);
    check("bad_drop_pulse", 32'(drop_pulse), 1);
    check("bad_level", 32'(level), 0);
    check("bad_out_valid", 32'(out_valid), 0);
    @(posedge clk); #1;
    @(negedge clk);
    check("bad_drop_pulse_one_cycle", 32'(drop_pulse), 0);
    @(posedge clk); #1;
    send_word(8'hC0, 1'b0, 1'b0);
    send_word(8'hC1, 1'b1, 1'b0);
    drain("after_bad");
    @(posedge clk); #1;

    // Oversize frame: 12 words into 8 entries, all accepted, then dropped.
    for (int i = 0; i < 12; i++) send_word(8'(8'hD0 + i), (i == 11), 1'b0);
    @(negedge clk);
    check("over_drop_pulse", 32'(drop_pulse), 1);
    check("over_level", 32'(level), 0);
    check("over_out_valid", 32'(out_valid), 0);
    check("over_frame_count", 32'(frame_count), 0);
    @(posedge clk); #1;
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #500000;
    n_tests++; n_fail++;
    $display("FAIL watchdog: simulation still running at 500000, expected completion");
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
